// File: rtl/dense_mac_seq_layer.sv
// Time-multiplexed dense layer: LANES MAC units sweep OUTPUT_SIZE/LANES passes over
// an input vector, reading one weight row per cycle from an external synchronous ROM.
module dense_mac_seq_layer #(
  parameter int WIDTH       = 16,
  parameter int NFRAC       = 10,
  parameter int INPUT_SIZE  = 128,
  parameter int OUTPUT_SIZE = 16,
  parameter int LANES       = 4,
  parameter int RELU        = 1,
  localparam int PASSES     = OUTPUT_SIZE / LANES,
  localparam int AW         = $clog2(PASSES * INPUT_SIZE)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [INPUT_SIZE-1:0][WIDTH-1:0]    in_data,
  input  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   biases,
  output logic [AW-1:0]                       w_addr,
  input  logic [LANES-1:0][WIDTH-1:0]         w_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   out_data
);

  localparam int KW   = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int PW   = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int ACCW = 2 * WIDTH + $clog2(INPUT_SIZE) + 1;

  localparam logic [KW-1:0]          K_LAST   = KW'(INPUT_SIZE - 1);
  localparam logic [PW-1:0]          P_LAST   = PW'(PASSES - 1);
  localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(1) <<< (NFRAC - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN  = -SAT_MAX - ACCW'(1);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_WB, S_DONE} state_t;

  state_t                               state_q, state_d;
  logic [PW-1:0]                        p_q;
  logic [KW-1:0]                        k_q;
  logic                                 load_bias;
  logic [PW-1:0]                        bias_pass;
  logic                                 mac_en_q;
  logic [INPUT_SIZE-1:0][WIDTH-1:0]     in_q;
  logic [WIDTH-1:0]                     x_q;
  logic signed [ACCW-1:0]               acc_q    [LANES];
  logic signed [ACCW-1:0]               bias_ext [LANES];
  logic signed [ACCW-1:0]               prod_ext [LANES];
  logic [LANES-1:0][WIDTH-1:0]          res;
  logic [PASSES-1:0][LANES-1:0][WIDTH-1:0] bias_v, out_q;

  // Same bit layout as the flat vectors, indexed as [pass][lane].
  assign bias_v   = biases;
  assign out_data = out_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    load_bias = 1'b0;
    bias_pass = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_addr    = '0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d   = S_MAC;
          load_bias = 1'b1;
        end
      end
      S_MAC: begin
        w_addr = AW'(int'(p_q) * INPUT_SIZE + int'(k_q));
        if (k_q == K_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_WB;
      S_WB: begin
        if (p_q == P_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_MAC;
          load_bias = 1'b1;
          bias_pass = p_q + PW'(1);
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q      <= '0;
      k_q      <= '0;
      mac_en_q <= 1'b0;
    end else begin
      // The product for address k is formed one cycle later, when the ROM row arrives.
      mac_en_q <= (state_q == S_MAC);
      unique case (state_q)
        S_IDLE: begin
          p_q <= '0;
          k_q <= '0;
        end
        S_MAC: k_q <= (k_q == K_LAST) ? '0 : k_q + KW'(1);
        S_WB: begin
          k_q <= '0;
          if (p_q != P_LAST) p_q <= p_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the captured vector and operand pipe are pure datapath; they need no reset
  // because nothing consumes them before a handshake refills them.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_valid) in_q <= in_data;
    x_q <= in_q[k_q];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    shifted;
    logic [WIDTH-1:0]          r;

    assign prod        = $signed(x_q) * $signed(w_data[l]);
    assign prod_ext[l] = ACCW'(prod);
    assign bias_ext[l] = ACCW'($signed(bias_v[bias_pass][l])) <<< NFRAC;
    assign shifted     = (acc_q[l] + RND_HALF) >>> NFRAC;

    always_comb begin
      if (shifted > SAT_MAX)      r = SAT_MAX[WIDTH-1:0];
      else if (shifted < SAT_MIN) r = SAT_MIN[WIDTH-1:0];
      else                        r = shifted[WIDTH-1:0];
      if (RELU != 0 && r[WIDTH-1]) r = '0;
    end

    assign res[l] = r;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else if (load_bias) begin
      for (int l = 0; l < LANES; l++) acc_q[l] <= bias_ext[l];
    end else if (mac_en_q) begin
      for (int l = 0; l < LANES; l++) acc_q[l] <= acc_q[l] + prod_ext[l];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              out_q      <= '0;
    else if (state_q == S_WB)  out_q[p_q] <= res;
  end

endmodule
